// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-bus request initiator feeding the fetch FIFO.
// Tracks outstanding requests and drops stale responses after redirects.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                setback_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  output logic [31:0]         fifo_addr_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e state_q, state_d;

  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         stored_addr_q, stored_addr_d;
  logic                pend_discard_q, pend_discard_d;
  logic [NUM_REQS-1:0] disc_q, disc_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [CW:0]  occ;
  logic [31:0]  br_addr;
  logic         redirect;
  logic         slot_free;
  logic         fifo_room;
  logic         issue;
  logic         push;
  logic         pop;
  logic         push_disc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect = branch_i | setback_i;
  assign br_addr  = {addr_i[31:2], 2'b00};

  always_comb begin
    occ = {1'b0, cnt_q};
    for (int i = 0; i < NUM_REQS; i++) begin
      occ = occ + {{CW{1'b0}}, fifo_busy_i[i]};
    end
  end

  // FIFO occupancy is irrelevant on a branch since the FIFO is cleared
  assign slot_free = cnt_q < CW'(NUM_REQS);
  assign fifo_room = branch_i | (occ < (CW+1)'(NUM_REQS));
  assign issue     = req_i & ~setback_i & slot_free & fifo_room;

  always_comb begin
    state_d        = state_q;
    fetch_addr_d   = fetch_addr_q;
    stored_addr_d  = stored_addr_q;
    pend_discard_d = pend_discard_q;
    instr_req_o    = 1'b0;
    instr_addr_o   = fetch_addr_q;
    push_disc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_addr_o = branch_i ? br_addr : fetch_addr_q;
        if (redirect) begin
          fetch_addr_d = br_addr;
        end
        if (issue) begin
          instr_req_o = 1'b1;
          if (instr_gnt_i) begin
            fetch_addr_d = instr_addr_o + 32'd4;
          end else begin
            state_d       = WAIT_GNT;
            stored_addr_d = instr_addr_o;
          end
        end
      end
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = stored_addr_q;
        if (redirect) begin
          fetch_addr_d = br_addr;
        end
        if (instr_gnt_i) begin
          push_disc      = pend_discard_q | redirect;
          pend_discard_d = 1'b0;
          state_d        = IDLE;
          if (!push_disc) begin
            fetch_addr_d = stored_addr_q + 32'd4;
          end
        end else if (redirect) begin
          pend_discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = instr_req_o & instr_gnt_i;
  assign pop  = instr_rvalid_i & (cnt_q != '0);

  always_comb begin
    disc_d = disc_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (redirect) begin
      disc_d = '1;
    end
    if (push) begin
      disc_d[wptr_q] = push_disc;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      fetch_addr_q   <= '0;
      stored_addr_q  <= '0;
      pend_discard_q <= 1'b0;
      disc_q         <= '0;
      rptr_q         <= '0;
      wptr_q         <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      fetch_addr_q   <= fetch_addr_d;
      stored_addr_q  <= stored_addr_d;
      pend_discard_q <= pend_discard_d;
      disc_q         <= disc_d;
      rptr_q         <= rptr_d;
      wptr_q         <= wptr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~disc_q[rptr_q] & ~redirect;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_clear_o = redirect;
  assign fifo_addr_o  = addr_i;
  assign busy_o       = instr_req_o | (cnt_q != '0);

`ifndef SYNTHESIS
  a_rvalid_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (cnt_q != '0));
  a_gnt_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> (cnt_q < CW'(NUM_REQS)));
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Vector table plus response scoreboard for ibex_fetch_req_ctrl.
// Inputs change 1ns after posedge, outputs are checked at negedge.
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        setback_i = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        busy_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        fifo_clear_o;
  logic [31:0] fifo_addr_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic [1:0]  fifo_busy_i = '0;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .setback_i      (setback_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .fifo_busy_i    (fifo_busy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        sb, req, br;
    logic [31:0] addr;
    logic        gnt, rv, err;
    logic [1:0]  fb;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid, e_clr, e_busy;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] sb_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic vec_t mk(
    input logic sb, req, br, input logic [31:0] addr,
    input logic gnt, rv, err, input logic [1:0] fb,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_valid, e_clr, e_busy);
    vec_t v;
    v.sb = sb; v.req = req; v.br = br; v.addr = addr;
    v.gnt = gnt; v.rv = rv; v.err = err; v.fb = fb;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_clr = e_clr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int tag);
    logic [32:0] e;
    logic [31:0] rd;
    rd = 32'hC0DE_0000 | 32'(tag);
    @(posedge clk_i);
    #1;
    setback_i      = v.sb;
    req_i          = v.req;
    branch_i       = v.br;
    addr_i         = v.addr;
    instr_gnt_i    = v.gnt;
    instr_rvalid_i = v.rv;
    instr_rdata_i  = rd;
    instr_err_i    = v.err;
    fifo_busy_i    = v.fb;
    if (v.e_valid) sb_q.push_back({v.err, rd});
    @(negedge clk_i);
    chk("instr_req", tag, 32'(instr_req_o), 32'(v.e_req));
    chk("instr_addr", tag, instr_addr_o, v.e_addr);
    chk("busy", tag, 32'(busy_o), 32'(v.e_busy));
    chk("fifo_clear", tag, 32'(fifo_clear_o), 32'(v.e_clr));
    chk("fifo_valid", tag, 32'(fifo_valid_o), 32'(v.e_valid));
    if (v.e_clr) chk("fifo_addr", tag, fifo_addr_o, v.addr);
    if (fifo_valid_o) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_push", tag, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("fifo_rdata", tag, fifo_rdata_o, e[31:0]);
        chk("fifo_err", tag, 32'(fifo_err_o), 32'(e[32]));
      end
    end
  endtask

  initial begin
    // sb req br addr gnt rv err fb | req addr valid clr busy
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h0,  0,0,0));
    tbl.push_back(mk(0,1,1,32'h102,1,0,0,2'b00, 1,32'h100,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h104,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 0,32'h108,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,1,0,2'b00, 0,32'h108,1,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h108,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h10C,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h10C,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h10C,0,0,0));
    tbl.push_back(mk(0,1,1,32'h100,0,0,0,2'b00, 1,32'h100,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  0,0,0,2'b00, 1,32'h100,0,0,1));
    tbl.push_back(mk(0,1,1,32'h200,0,0,0,2'b00, 1,32'h100,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h100,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,1,0,2'b00, 1,32'h200,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h204,1,0,1));
    tbl.push_back(mk(0,1,1,32'h100,1,0,0,2'b00, 1,32'h100,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h104,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  0,1,0,2'b00, 0,32'h108,1,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h108,0,0,1));
    tbl.push_back(mk(0,0,1,32'h300,0,1,0,2'b00, 0,32'h300,0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h300,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h300,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b11, 0,32'h300,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b11, 0,32'h300,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b01, 1,32'h300,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b01, 0,32'h304,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b01, 0,32'h304,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h304,0,0,0));
    tbl.push_back(mk(0,1,1,32'h400,1,0,0,2'b00, 1,32'h400,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h404,0,0,1));
    tbl.push_back(mk(1,1,0,32'h500,0,0,0,2'b00, 0,32'h408,0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h500,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h500,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h500,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h500,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,1,2'b00, 0,32'h504,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h504,0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,  0,0,0,2'b00, 1,32'h504,0,0,1));
    tbl.push_back(mk(1,1,0,32'h600,0,0,0,2'b00, 1,32'h504,0,1,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,0,0,2'b00, 1,32'h504,0,0,1));
    tbl.push_back(mk(0,1,0,32'h0,  1,1,0,2'b00, 1,32'h600,0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,1,0,2'b00, 0,32'h604,1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,  0,0,0,2'b00, 0,32'h604,0,0,0));

    #3;
    chk("rst_instr_req", -1, 32'(instr_req_o), 32'd0);
    chk("rst_instr_addr", -1, instr_addr_o, 32'd0);
    chk("rst_busy", -1, 32'(busy_o), 32'd0);
    chk("rst_fifo_valid", -1, 32'(fifo_valid_o), 32'd0);
    chk("rst_fifo_clear", -1, 32'(fifo_clear_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Address wrap at the top of the address space
    apply(mk(0,1,1,32'hFFFF_FFFE,1,0,0,2'b00, 1,32'hFFFF_FFFC,0,1,1), 100);
    apply(mk(0,1,0,32'h0,1,0,0,2'b00, 1,32'h0,0,0,1), 101);
    apply(mk(0,0,0,32'h0,0,1,0,2'b00, 0,32'h4,1,0,1), 102);
    apply(mk(0,0,0,32'h0,0,1,0,2'b00, 0,32'h4,1,0,1), 103);
    apply(mk(0,0,0,32'h0,0,0,0,2'b00, 0,32'h4,0,0,0), 104);

    chk("sb_leftover", 999, 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
